// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared opcodes, FSM states and coordinate widths for the blitter
package gfx_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [1:0] OP_FILL     = 2'b00;
  localparam logic [1:0] OP_DRAW     = 2'b01;
  localparam logic [1:0] OP_DRAW_KEY = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DRAW_RD,
    ST_DRAW_WR,
    ST_FIN
  } state_t;
endpackage

// File: rtl/gfx_raster_walker.sv
// rtl/gfx_raster_walker.sv - raster-order x/y/row_base stepping over an inclusive rectangle
// Outputs describe the current pixel; on load they bypass to the top-left pixel so it can be used the same cycle.
module gfx_raster_walker
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int VRAM_AW  = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [X_W-1:0]     i_tl_x,
  input  logic [X_W-1:0]     i_br_x,
  input  logic [Y_W-1:0]     i_tl_y,
  input  logic [Y_W-1:0]     i_br_y,
  output logic [VRAM_AW-1:0] o_addr,
  output logic               o_clipped,
  output logic               o_last
);
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [VRAM_AW-1:0] r_rb;
  logic [X_W-1:0]     w_cur_x;
  logic [Y_W-1:0]     w_cur_y;
  logic [VRAM_AW-1:0] w_cur_rb;
  logic [VRAM_AW-1:0] w_rb0;
  logic               w_row_end;

  assign w_rb0     = VRAM_AW'(32'(i_tl_y) * SCREEN_W);
  assign w_cur_x   = i_load ? i_tl_x : r_x;
  assign w_cur_y   = i_load ? i_tl_y : r_y;
  assign w_cur_rb  = i_load ? w_rb0  : r_rb;
  assign w_row_end = (w_cur_x == i_br_x);

  assign o_addr    = w_cur_rb + VRAM_AW'(w_cur_x);
  assign o_clipped = (32'(w_cur_x) >= SCREEN_W) || (32'(w_cur_y) >= SCREEN_H);
  assign o_last    = w_row_end && (w_cur_y == i_br_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_rb <= '0;
    end else if (i_step) begin
      if (w_row_end) begin
        r_x  <= i_tl_x;
        r_y  <= w_cur_y + 1'b1;
        r_rb <= w_cur_rb + VRAM_AW'(SCREEN_W);
      end else begin
        r_x  <= w_cur_x + 1'b1;
        r_y  <= w_cur_y;
        r_rb <= w_cur_rb;
      end
    end else if (i_load) begin
      r_x  <= i_tl_x;
      r_y  <= i_tl_y;
      r_rb <= w_rb0;
    end
  end
endmodule

// File: rtl/gfx_blitter.sv
// rtl/gfx_blitter.sv - MMIO rectangle fill / sprite copy engine driving the VRAM write port
// Owns the command FSM, ROM address counter and registered VRAM outputs.
module gfx_blitter
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 12,
  parameter int ROM_AW   = 12,
  parameter int VRAM_AW  = 19
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [1:0]                                          opcode,
  input  logic [X_W-1:0]                                      tl_x,
  input  logic [X_W-1:0]                                      br_x,
  input  logic [Y_W-1:0]                                      tl_y,
  input  logic [Y_W-1:0]                                      br_y,
  input  logic [((COLOR_W > ROM_AW) ? COLOR_W : ROM_AW)-1:0] arg,
  input  logic [COLOR_W-1:0]                                  key,
  output logic                                                busy,
  output logic                                                done,
  output logic [ROM_AW-1:0]                                   rom_addr,
  input  logic [COLOR_W-1:0]                                  rom_data,
  output logic                                                vram_we,
  output logic [VRAM_AW-1:0]                                  vram_addr,
  output logic [COLOR_W-1:0]                                  vram_data
);
  localparam int ARG_W = (COLOR_W > ROM_AW) ? COLOR_W : ROM_AW;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [X_W-1:0]     r_tl_x, r_br_x;
  logic [Y_W-1:0]     r_tl_y, r_br_y;
  logic [ARG_W-1:0]   r_arg;
  logic [COLOR_W-1:0] r_key;
  logic               r_wlast;
  logic               w_load, w_step, w_degen, w_fill_emit;
  logic               w_clipped, w_last, w_transparent;
  logic [VRAM_AW-1:0] w_addr;

  assign w_degen       = (r_br_x < r_tl_x) || (r_br_y < r_tl_y) || (r_op == OP_NOP);
  assign w_transparent = (r_op == OP_DRAW_KEY) && (rom_data == r_key);
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done          = (r_state == ST_FIN);

  gfx_raster_walker #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .VRAM_AW (VRAM_AW)
  ) u_walker (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_tl_x   (r_tl_x),
    .i_br_x   (r_br_x),
    .i_tl_y   (r_tl_y),
    .i_br_y   (r_br_y),
    .o_addr   (w_addr),
    .o_clipped(w_clipped),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Fill emits pixel 0 already in SETUP so writes appear from cycle 2; r_wlast marks the final one.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fill_emit = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_SETUP;
      ST_SETUP: begin
        w_load = 1'b1;
        if (w_degen) begin
          w_next = ST_FIN;
        end else if (r_op == OP_FILL) begin
          w_step      = 1'b1;
          w_fill_emit = 1'b1;
          w_next      = ST_FILL;
        end else begin
          w_next = ST_DRAW_RD;
        end
      end
      ST_FILL: begin
        if (r_wlast) begin
          w_next = ST_FIN;
        end else begin
          w_step      = 1'b1;
          w_fill_emit = 1'b1;
        end
      end
      ST_DRAW_RD: w_next = ST_DRAW_WR;
      ST_DRAW_WR: begin
        w_step = 1'b1;
        w_next = w_last ? ST_FIN : ST_DRAW_RD;
      end
      ST_FIN:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_NOP;
      r_tl_x    <= '0;
      r_br_x    <= '0;
      r_tl_y    <= '0;
      r_br_y    <= '0;
      r_arg     <= '0;
      r_key     <= '0;
      r_wlast   <= 1'b0;
      rom_addr  <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= 1'b0;
      if (r_state == ST_IDLE && start) begin
        r_op   <= opcode;
        r_tl_x <= tl_x;
        r_br_x <= br_x;
        r_tl_y <= tl_y;
        r_br_y <= br_y;
        r_arg  <= arg;
        r_key  <= key;
      end
      if (r_state == ST_SETUP) rom_addr <= r_arg[ROM_AW-1:0];
      if (w_fill_emit) begin
        vram_we   <= !w_clipped;
        vram_addr <= w_addr;
        vram_data <= r_arg[COLOR_W-1:0];
        r_wlast   <= w_last;
      end
      if (r_state == ST_DRAW_WR) begin
        vram_we   <= !w_clipped && !w_transparent;
        vram_addr <= w_addr;
        vram_data <= rom_data;
        rom_addr  <= rom_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gfx_blitter.sv
// tb/tb_gfx_blitter.sv - directed vector bench for gfx_blitter with a synchronous sprite ROM model
module tb_gfx_blitter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [9:0]  tl_x = '0, br_x = '0;
  logic [8:0]  tl_y = '0, br_y = '0;
  logic [11:0] arg = '0, key = '0;
  logic        busy, done, vram_we;
  logic [11:0] rom_addr, rom_data, vram_data;
  logic [18:0] vram_addr;
  logic [11:0] rom [0:4095];

  int n_pass = 0, n_total = 0;
  int wr_a[$], wr_d[$], wr_c[$];
  int ra [0:127];
  int done_c, done_n, busy_n, busy_at_done;

  typedef struct {
    string      name;
    logic [1:0] op;
    int         tlx, tly, brx, bry, argv, keyv, nw;
    int         a [4];
    int         d [4];
    int         done_cyc;
  } vec_t;

  vec_t vecs [10];

  gfx_blitter dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .tl_x(tl_x), .br_x(br_x), .tl_y(tl_y), .br_y(br_y),
    .arg(arg), .key(key), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Cycle c is sampled at the c-th falling edge after start is raised (start accepted at cycle 0).
  task automatic run_cmd(input vec_t v, input int poke);
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    done_c = -1; done_n = 0; busy_n = 0; busy_at_done = 0;
    @(negedge clk);
    opcode = v.op; tl_x = 10'(v.tlx); tl_y = 9'(v.tly); br_x = 10'(v.brx); br_y = 9'(v.bry);
    arg = 12'(v.argv); key = 12'(v.keyv); start = 1'b1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin
        opcode = 2'b00; tl_x = 10'd0; tl_y = 9'd0; br_x = 10'd5; br_y = 9'd5; arg = 12'h0F0;
      end
      ra[c] = int'(rom_addr);
      if (vram_we) begin
        wr_a.push_back(int'(vram_addr)); wr_d.push_back(int'(vram_data)); wr_c.push_back(c);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (busy) busy_at_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, " done_cycle"}, done_c, v.done_cyc);
    chk({v.name, " done_pulses"}, done_n, 1);
    chk({v.name, " busy_cycles"}, busy_n, v.done_cyc - 1);
    chk({v.name, " busy_at_done"}, busy_at_done, 0);
    chk({v.name, " write_count"}, wr_a.size(), v.nw);
    for (int i = 0; i < v.nw && i < wr_a.size(); i++) begin
      chk($sformatf("%s addr%0d", v.name, i), wr_a[i], v.a[i]);
      chk($sformatf("%s data%0d", v.name, i), wr_d[i], v.d[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 12'h5A5;
    rom[12'h100] = 12'h000; rom[12'h101] = 12'hABC; rom[12'h102] = 12'h000;
    rom[12'hFFF] = 12'h777; rom[12'h000] = 12'h111;

    vecs[0] = '{"fill4", 2'b00, 10, 5, 11, 6, 'hF00, 0, 4, '{3210, 3211, 3850, 3851}, '{'hF00, 'hF00, 'hF00, 'hF00}, 6};
    vecs[1] = '{"clip_x", 2'b00, 638, 0, 641, 0, 'h0AB, 0, 2, '{638, 639, 0, 0}, '{'h0AB, 'h0AB, 0, 0}, 6};
    vecs[2] = '{"degen_x", 2'b00, 20, 0, 10, 0, 'h111, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 2};
    vecs[3] = '{"nop", 2'b11, 0, 0, 3, 3, 'h222, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 2};
    vecs[4] = '{"degen_y", 2'b00, 0, 5, 3, 4, 'h333, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 2};
    vecs[5] = '{"corner1x1", 2'b00, 639, 479, 639, 479, 'h123, 0, 1, '{307199, 0, 0, 0}, '{'h123, 0, 0, 0}, 3};
    vecs[6] = '{"clip_y", 2'b00, 0, 479, 0, 480, 'h456, 0, 1, '{306560, 0, 0, 0}, '{'h456, 0, 0, 0}, 4};
    vecs[7] = '{"draw_key", 2'b10, 0, 0, 2, 0, 'h100, 'h000, 1, '{1, 0, 0, 0}, '{'hABC, 0, 0, 0}, 8};
    vecs[8] = '{"draw", 2'b01, 0, 0, 2, 0, 'h100, 'h000, 3, '{0, 1, 2, 0}, '{'h000, 'hABC, 'h000, 0}, 8};
    vecs[9] = '{"draw_wrap", 2'b01, 5, 1, 6, 1, 'hFFF, 0, 2, '{645, 646, 0, 0}, '{'h777, 'h111, 0, 0}, 6};

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset vram_we", int'(vram_we), 0);
    chk("reset vram_addr", int'(vram_addr), 0);
    chk("reset rom_addr", int'(rom_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      run_cmd(vecs[k], -1);
      check_vec(vecs[k]);
    end

    run_cmd(vecs[0], -1);
    for (int i = 0; i < 4 && i < wr_c.size(); i++) chk($sformatf("fill4 write_cycle%0d", i), wr_c[i], 2 + i);

    run_cmd(vecs[7], 3);
    check_vec(vecs[7]);
    chk("key rom_addr c2", ra[2], 'h100);
    chk("key rom_addr c4", ra[4], 'h101);
    chk("key rom_addr c6", ra[6], 'h102);
    if (wr_c.size() > 0) chk("key write_cycle", wr_c[0], 6);

    @(negedge clk);
    opcode = 2'b01; tl_x = 10'd4; tl_y = 9'd3; br_x = 10'd9; br_y = 9'd3; arg = 12'h101; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid busy", int'(busy), 1);
    chk("mid vram_addr", int'(vram_addr), 1924);
    chk("mid rom_addr", int'(rom_addr), 'h102);
    #2 rst = 1'b1;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    chk("async vram_we", int'(vram_we), 0);
    chk("async vram_addr", int'(vram_addr), 0);
    chk("async vram_data", int'(vram_data), 0);
    chk("async rom_addr", int'(rom_addr), 0);
    done_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("reset no_done", done_n, 0);
    rst = 1'b0;

    begin
      vec_t v;
      v = '{"post_reset", 2'b00, 7, 2, 7, 2, 'h3C3, 0, 1, '{1287, 0, 0, 0}, '{'h3C3, 0, 0, 0}, 3};
      run_cmd(v, -1);
      check_vec(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
